fpu_add_sequencer: RTL and testbench
====================================

// Module: fpu_add_sequencer
// PURPOSE
// - Multi-cycle control FSM for the single-precision FPU add/sub datapath.
// - Accepts operand-pair requests (valid/ready) and pulses the fetch stage valid.
// - Sequences stages FETCH -> ALIGN -> EXEC -> NORM and returns a result valid.
// - Datapath registers live outside this block; it only issues enables/shift
//   amounts and consumes status flags. ZERO/NaN/INF operands bypass straight to DONE.
// PARAMETERS
// - SHIFT_PER_CYCLE  4   max mantissa right-shift per ALIGN cycle (1..25)
// - NORM_MAX_CYCLES  26  NORM cycles allowed before err_o is raised
// - MANT_W           24  mantissa width incl. hidden bit; shift saturates at MANT_W+1
// PORTS
// - clk_i           in   1      clock, all state on rising edge
// - rst_ni          in   1      asynchronous reset, active low
// - req_valid_i     in   1      operand pair + op presented
// - req_ready_o     out  1      high only in IDLE
// - op_sub_i        in   1      1 = subtract; captured on accept
// - fetch_valid_o   out  1      drives fetch stage valid_i (hidden-bit insert)
// - num_status_i    in   2      fetch stage status (ZERO_res/NAN_or_INF/OK_state)
// - exp_diff_i      in   8      |exp_a - exp_b| from fetch outputs, sampled in FETCH
// - align_en_o      out  1      align-shift register enable
// - align_shift_o   out  5      shift amount this ALIGN cycle
// - exec_en_o       out  1      add/sub unit enable, 1 cycle
// - exec_sub_o      out  1      registered op_sub_i
// - norm_en_o       out  1      normaliser step enable
// - norm_done_i     in   1      normaliser reports MSB set or result zero
// - res_valid_o     out  1      result available
// - res_ready_i     in   1      consumer accepts result
// - res_status_o    out  2      status registered in FETCH (OK_state if normal path)
// - err_o           out  1      sticky: NORM timeout; cleared by reset or next accept
// - busy_o          out  1      state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE; req_ready_o=1; every other output 0; counters 0; res_status_o=OK_state.
// - IDLE: accept on req_valid_i & req_ready_o; capture op_sub_i, clear err_o -> FETCH.
// - FETCH (1 cycle): fetch_valid_o=1; register num_status_i; rem = min(exp_diff_i, MANT_W+1).
//   status != OK_state -> DONE (bypass). rem==0 -> EXEC. else -> ALIGN.
// - ALIGN: align_en_o=1; align_shift_o = min(rem, SHIFT_PER_CYCLE); rem -= shift;
//   -> EXEC in the cycle rem reaches 0. Cycles = ceil(min(d,25)/SHIFT_PER_CYCLE).
// - EXEC (1 cycle): exec_en_o=1, exec_sub_o valid -> NORM; norm counter cleared.
// - NORM: norm_en_o=1 each cycle; norm_done_i=1 -> DONE. Counter hits
//   NORM_MAX_CYCLES without done -> err_o=1, -> DONE.
// - DONE: res_valid_o=1, held stable with res_status_o until res_ready_i; on
//   handshake -> IDLE (ready asserted next cycle; no same-cycle re-accept).
// - Latency accept->res_valid: bypass 2; normal 3 + ALIGN cycles + NORM cycles.
// - Exactly one of fetch/align/exec/norm enables high per cycle; none in IDLE/DONE.
// - Inputs other than req_* ignored in IDLE; req_valid_i ignored while busy.
// - Illegal state encoding -> IDLE next cycle.
// - rst_ni low in any state: immediate return to reset values; no result emitted.
// STRUCTURE
// - float_types_pkg gains: num_status_e (2b: OK_state, ZERO_res, NAN_or_INF),
//   fpu_seq_state_e {IDLE,FETCH,ALIGN,EXEC,NORM,DONE}, MANT_W/EXP_W localparams.
// - Single module; FSM + align remainder counter + norm counter. No sub-module.
// TESTING
// - Reset mid-ALIGN (d=20) -> all outputs 0, req_ready_o=1, no res_valid_o ever.
// - d=0, norm_done_i on 1st NORM cycle -> no ALIGN; res_valid_o 4 cycles after accept.
// - d=10, SHIFT=4 -> align_shift_o = 4,4,2 on 3 consecutive cycles, then exec_en_o.
// - d=200 -> saturates to 25: shifts 4,4,4,4,4,4,1 (7 cycles).
// - num_status_i=NAN_or_INF in FETCH -> no align/exec/norm enables;
//   res_valid_o 2 cycles after accept, res_status_o=NAN_or_INF.
// - norm_done_i held 0 -> 26 norm_en_o cycles, err_o=1, res_valid_o;
//   res_ready_i low 5 cycles -> outputs stable; next accept clears err_o.

Source files
------------

// File: rtl/float_types_pkg.sv
// Shared single-precision FPU types: operand status codes, add/sub sequencer
// states and basic field widths.
// Latency: n/a (types only). Backpressure: n/a.
package float_types_pkg;

  localparam int MANT_W = 24;  // mantissa width including hidden bit
  localparam int EXP_W  = 8;

  // OK_state is the all-zero code so a cleared status register reads "normal".
  typedef enum logic [1:0] {
    OK_state   = 2'b00,
    ZERO_res   = 2'b01,
    NAN_or_INF = 2'b10
  } num_status_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ALIGN = 3'd2,
    EXEC  = 3'd3,
    NORM  = 3'd4,
    DONE  = 3'd5
  } fpu_seq_state_e;

endpackage

// File: rtl/fpu_add_sequencer.sv
// Control FSM for the FPU add/sub datapath: FETCH -> ALIGN -> EXEC -> NORM -> DONE.
// Latency accept->res_valid_o: 2 on special-operand bypass, else 3 + ALIGN + NORM cycles.
// Backpressure: one request in flight; req_ready_o only in IDLE, result held until res_ready_i.
// Ports:
//   clk_i/rst_ni                       clock, async active-low reset
//   req_valid_i/req_ready_o/op_sub_i   request handshake and captured operation
//   fetch_valid_o, num_status_i, exp_diff_i         fetch stage control/status
//   align_en_o/align_shift_o, exec_en_o/exec_sub_o, norm_en_o/norm_done_i  stage control
//   res_valid_o/res_ready_i/res_status_o            result handshake and status
//   err_o (sticky NORM timeout), busy_o (not IDLE)
module fpu_add_sequencer
  import float_types_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = 4,
  parameter int NORM_MAX_CYCLES = 26,
  parameter int MANT_W          = float_types_pkg::MANT_W
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        op_sub_i,
  output logic        fetch_valid_o,
  input  num_status_e num_status_i,
  input  logic [7:0]  exp_diff_i,
  output logic        align_en_o,
  output logic [4:0]  align_shift_o,
  output logic        exec_en_o,
  output logic        exec_sub_o,
  output logic        norm_en_o,
  input  logic        norm_done_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output num_status_e res_status_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int NC_W = $clog2(NORM_MAX_CYCLES + 1);
  // Shifting by MANT_W+1 already pushes every bit (incl. guard) out, so larger
  // exponent differences are equivalent and are clamped there.
  localparam logic [7:0]      SAT_E   = 8'(MANT_W + 1);
  localparam logic [4:0]      SAT_R   = 5'(MANT_W + 1);
  localparam logic [4:0]      SPC     = 5'(SHIFT_PER_CYCLE);
  localparam logic [NC_W-1:0] NC_LAST = NC_W'(NORM_MAX_CYCLES - 1);

  fpu_seq_state_e    r_state, w_state_nxt;
  logic [4:0]        r_rem, w_rem_nxt;
  logic [NC_W-1:0]   r_ncnt, w_ncnt_nxt;
  logic              r_err, w_err_nxt;
  logic              r_op_sub, w_op_sub_nxt;
  num_status_e       r_status, w_status_nxt;
  logic [4:0]        w_sat;
  logic [4:0]        w_shift;

  assign w_sat = (exp_diff_i > SAT_E) ? SAT_R : exp_diff_i[4:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_ncnt   <= '0;
      r_err    <= 1'b0;
      r_op_sub <= 1'b0;
      r_status <= OK_state;
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      r_ncnt   <= w_ncnt_nxt;
      r_err    <= w_err_nxt;
      r_op_sub <= w_op_sub_nxt;
      r_status <= w_status_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_ncnt_nxt    = r_ncnt;
    w_err_nxt     = r_err;
    w_op_sub_nxt  = r_op_sub;
    w_status_nxt  = r_status;
    w_shift       = '0;
    req_ready_o   = 1'b0;
    fetch_valid_o = 1'b0;
    align_en_o    = 1'b0;
    exec_en_o     = 1'b0;
    norm_en_o     = 1'b0;
    res_valid_o   = 1'b0;

    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_op_sub_nxt = op_sub_i;
          w_err_nxt    = 1'b0;
          w_state_nxt  = FETCH;
        end
      end
      FETCH: begin
        fetch_valid_o = 1'b1;
        w_status_nxt  = num_status_i;
        w_rem_nxt     = w_sat;
        if (num_status_i != OK_state) w_state_nxt = DONE;
        else if (w_sat == '0)         w_state_nxt = EXEC;
        else                          w_state_nxt = ALIGN;
      end
      ALIGN: begin
        align_en_o = 1'b1;
        w_shift    = (r_rem > SPC) ? SPC : r_rem;
        w_rem_nxt  = r_rem - w_shift;
        // Leave on the cycle that issues the final partial shift.
        if (r_rem == w_shift) w_state_nxt = EXEC;
      end
      EXEC: begin
        exec_en_o   = 1'b1;
        w_ncnt_nxt  = '0;
        w_state_nxt = NORM;
      end
      NORM: begin
        norm_en_o = 1'b1;
        // A done on the last permitted cycle still counts as success.
        if (norm_done_i) begin
          w_state_nxt = DONE;
        end else if (r_ncnt == NC_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_ncnt_nxt = r_ncnt + NC_W'(1);
        end
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign align_shift_o = w_shift;
  assign exec_sub_o    = r_op_sub;
  assign res_status_o  = r_status;
  assign err_o         = r_err;
  assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// Scoreboard bench for fpu_add_sequencer: expected per-request results are queued
// when a request is driven and compared when res_valid_o appears.
// Stage enables and per-cycle shift amounts are checked against a reference sequence.
module tb_fpu_add_sequencer;
  import float_types_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        op_sub_i = 1'b0;
  logic        fetch_valid_o;
  num_status_e num_status_i = OK_state;
  logic [7:0]  exp_diff_i = '0;
  logic        align_en_o;
  logic [4:0]  align_shift_o;
  logic        exec_en_o;
  logic        exec_sub_o;
  logic        norm_en_o;
  logic        norm_done_i = 1'b0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  num_status_e res_status_o;
  logic        err_o;
  logic        busy_o;

  fpu_add_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .op_sub_i(op_sub_i),
    .fetch_valid_o(fetch_valid_o), .num_status_i(num_status_i), .exp_diff_i(exp_diff_i),
    .align_en_o(align_en_o), .align_shift_o(align_shift_o),
    .exec_en_o(exec_en_o), .exec_sub_o(exec_sub_o),
    .norm_en_o(norm_en_o), .norm_done_i(norm_done_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_status_o(res_status_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          lat;
    int          na;
    int          nn;
    num_status_e st;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // d: exponent difference, st: fetch status, nd: NORM cycles before done
  // (>=26 means never), hold: cycles res_ready_i stays low in DONE.
  task automatic run_txn(input int d, input num_status_e st, input int nd,
                         input bit sub, input int hold);
    exp_t       e;
    logic [4:0] sh_q[$];
    int         sat, rem, s, c, nn, na, lat, sum;
    bit         seen, byp;
    byp = (st != OK_state);
    sat = (d > 25) ? 25 : d;
    e.na = 0; e.nn = 0; e.err = 1'b0; e.st = st;
    if (!byp) begin
      rem = sat;
      while (rem > 0) begin
        s = (rem > 4) ? 4 : rem;
        sh_q.push_back(5'(s));
        rem -= s;
        e.na++;
      end
      e.nn  = (nd < 26) ? nd + 1 : 26;
      e.err = (nd >= 26);
    end
    e.lat = byp ? 2 : 3 + e.na + e.nn;
    sb_q.push_back(e);

    @(negedge clk_i);
    exp_diff_i   = 8'((d > 255) ? 255 : d);
    num_status_i = st;
    op_sub_i     = sub;
    req_valid_i  = 1'b1;
    chk("req_ready_idle", {31'd0, req_ready_o}, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    c = 1; nn = 0; na = 0; seen = 1'b0; lat = 0;
    while (!seen && c < 200) begin
      sum = int'(fetch_valid_o) + int'(align_en_o) + int'(exec_en_o) + int'(norm_en_o);
      if (res_valid_o) begin
        seen = 1'b1;
        lat  = c;
        chk("enables_in_done", sum, 0);
      end else begin
        chk("one_enable", sum, 1);
        if (c == 1) begin
          chk("fetch_first", {31'd0, fetch_valid_o}, 1);
          chk("err_cleared", {31'd0, err_o}, 0);
        end
        if (align_en_o) begin
          na++;
          s = (sh_q.size() > 0) ? int'(sh_q.pop_front()) : 0;
          chk("align_shift", {27'd0, align_shift_o}, s);
        end
        if (exec_en_o) chk("exec_sub", {31'd0, exec_sub_o}, {31'd0, sub});
        if (norm_en_o) begin
          nn++;
          norm_done_i = (nn == nd + 1);
        end else begin
          norm_done_i = 1'b0;
        end
        @(negedge clk_i);
        c++;
      end
    end
    norm_done_i = 1'b0;
    chk("res_valid_seen", {31'd0, seen}, 1);
    e = sb_q.pop_front();
    chk("latency", lat, e.lat);
    chk("align_cycles", na, e.na);
    chk("norm_cycles", nn, e.nn);
    chk("res_status", {30'd0, res_status_o}, {30'd0, e.st});
    chk("err", {31'd0, err_o}, {31'd0, e.err});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_i);
      chk("hold_valid", {31'd0, res_valid_o}, 1);
      chk("hold_status", {30'd0, res_status_o}, {30'd0, e.st});
      chk("hold_err", {31'd0, err_o}, {31'd0, e.err});
      chk("hold_no_ready", {31'd0, req_ready_o}, 0);
    end
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    chk("post_valid", {31'd0, res_valid_o}, 0);
    chk("post_ready", {31'd0, req_ready_o}, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcnt, ecnt;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", {31'd0, req_ready_o}, 1);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_valid", {31'd0, res_valid_o}, 0);
    chk("rst_enables", {28'd0, fetch_valid_o, align_en_o, exec_en_o, norm_en_o}, 0);
    chk("rst_shift", {27'd0, align_shift_o}, 0);
    chk("rst_status", {30'd0, res_status_o}, {30'd0, OK_state});
    chk("rst_err_sub", {30'd0, err_o, exec_sub_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_txn(0,   OK_state,   0,  1'b0, 0);   // no ALIGN, latency 4
    run_txn(10,  OK_state,   2,  1'b1, 0);   // shifts 4,4,2
    run_txn(200, OK_state,   1,  1'b0, 1);   // saturates to 25
    run_txn(26,  OK_state,   0,  1'b1, 0);   // just above saturation
    run_txn(4,   OK_state,   3,  1'b0, 0);   // exactly one full shift
    run_txn(5,   NAN_or_INF, 0,  1'b1, 0);   // bypass
    run_txn(3,   ZERO_res,   0,  1'b0, 2);   // bypass
    run_txn(25,  OK_state,   30, 1'b1, 5);   // NORM timeout, err sticky
    run_txn(1,   OK_state,   25, 1'b0, 0);   // done on last allowed cycle
    for (int i = 0; i < 4; i++)
      run_txn($urandom_range(0, 40), OK_state, $urandom_range(0, 8), 1'($urandom_range(0, 1)), 0);

    // Reset in the middle of ALIGN.
    @(negedge clk_i);
    exp_diff_i = 8'd20; num_status_i = OK_state; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("align_before_rst", {31'd0, align_en_o}, 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, req_ready_o}, 1);
    chk("midrst_busy", {31'd0, busy_o}, 0);
    chk("midrst_enables", {28'd0, fetch_valid_o, align_en_o, exec_en_o, norm_en_o}, 0);
    chk("midrst_shift", {27'd0, align_shift_o}, 0);
    chk("midrst_valid_err", {30'd0, res_valid_o, err_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    vcnt = 0; ecnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      vcnt += int'(res_valid_o);
      ecnt += int'(align_en_o) + int'(exec_en_o) + int'(norm_en_o) + int'(busy_o);
    end
    chk("no_result_after_rst", vcnt, 0);
    chk("idle_after_rst", ecnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
